moore_seq_detector_param: RTL and testbench
===========================================

// Module: moore_seq_detector_param
// PURPOSE
//   Parametrised Moore serial-pattern detector: next generation of the fixed 4-bit
//   non-overlapping detector. Pattern is loadable at run time, length set by parameter,
//   overlapping/non-overlapping mode selected per cycle. Sits on a 1-bit serial stream;
//   registered pulse output feeds downstream framing/alignment logic.
// PARAMETERS
//   SEQ_LEN  4        pattern length in bits (2..32); in[] bits compared MSB-first
//   RST_PAT  4'b1011  pattern loaded at reset, width SEQ_LEN
//   CNT_W    8        width of match counter (SEQDET_COUNT_EN only)
// PORTS
//   clk        in   1        single clock, all logic on posedge
//   rst        in   1        asynchronous, active-low reset
//   in         in   1        serial data bit, sampled on posedge when en=1
//   en         in   1        bit-valid strobe; en=0 -> bit ignored, history holds
//   overlap    in   1        1 = overlapping detection, 0 = non-overlapping
//   pat_load   in   1        load pattern_in this cycle (priority over en)
//   pattern_in in   SEQ_LEN  new pattern; pattern_in[SEQ_LEN-1] is first bit expected
//   detected   out  1        registered 1-cycle match pulse (Moore)
//   match_cnt  out  CNT_W    saturating match count (0 when macro off)
//   cnt_clr    in   1        synchronous clear of match_cnt (ignored when macro off)
// BEHAVIOUR
//   Reset (rst=0, async): hist=0, fill=0, pattern=RST_PAT, detected=0, match_cnt=0.
//   State: hist[SEQ_LEN-1:0] shift reg (newest bit at [0]); fill counter 0..SEQ_LEN
//     (saturates at SEQ_LEN) = bits collected since last clear; pattern register.
//   Per posedge, priority order:
//     1 pat_load=1: pattern<=pattern_in, hist<=0, fill<=0, detected<=0. en/in ignored.
//     2 en=0: hist, fill hold; detected<=0.
//     3 en=1: nh={hist[SEQ_LEN-2:0],in}; nf=min(fill+1,SEQ_LEN).
//       match = (nf==SEQ_LEN) && (nh==pattern).
//       detected<=match.
//       match & overlap=0: hist<=0, fill<=0 (next match needs SEQ_LEN fresh bits).
//       match & overlap=1: hist<=nh, fill<=nf (suffix reused; e.g. 1011011 -> 2 hits).
//       no match: hist<=nh, fill<=nf.
//   Latency: detected high exactly in the cycle after the posedge sampling the last
//     pattern bit; never high two cycles in a row unless overlap=1 and the pattern
//     permits (e.g. all-ones pattern, continuous 1s -> detected high every en cycle).
//   overlap may change any cycle; it takes effect on the bit sampled that cycle.
//   Equivalent Moore FSM states: S0..S(SEQ_LEN-1) partial, SDET = match; shift-reg
//     form is mandatory so run-time patterns need no failure-table recompute.
//   Reset mid-sequence: all partial progress lost; first match needs SEQ_LEN new bits.
// CONFIGURATION
//   SEQDET_COUNT_EN defined: match_cnt increments on each detected<=1 event,
//     saturates at 2^CNT_W-1; cnt_clr=1 forces 0 (clear wins over same-cycle
//     increment); pat_load does not clear it.
//   SEQDET_COUNT_EN undefined: no counter logic; match_cnt tied to 0; cnt_clr unused.
// TESTING
//   T1 reset defaults, overlap=0, en=1, in=1,0,1,1 -> detected=1 one cycle after 4th bit.
//   T2 overlap=0, in=1,0,1,1,0,1,1 -> 1 pulse; overlap=1 same stream -> 2 pulses
//      (after bits 4 and 7).
//   T3 en=0 bubbles inserted between each bit of 1011 -> still 1 pulse; detected=0
//      during bubbles.
//   T4 pat_load pattern_in=4'b0110 after 3 bits of 1011; then 0,1,1,0 -> pulse; 1011
//      afterwards -> no pulse.
//   T5 rst pulsed low after bits 1,0,1 then in=1 -> no pulse; full 1011 -> pulse.
//   T6 (SEQDET_COUNT_EN, CNT_W=2) 5 matches -> match_cnt=3 saturated; cnt_clr -> 0.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// moore_seq_detector_param
//   Parametrised Moore serial-pattern detector. It watches a 1-bit serial stream
//   for a run-time loadable pattern of SEQ_LEN bits, compared MSB-first. The
//   output is a registered one-cycle pulse. Overlapping or non-overlapping
//   detection is chosen per cycle.
//
//   Optional feature: define SEQDET_COUNT_EN to build a saturating match counter.
//   When SEQDET_COUNT_EN is undefined, match_cnt is tied to 0 and cnt_clr is unused.
//
// Parameters
//   SEQ_LEN  pattern length in bits (2..32)
//   RST_PAT  pattern loaded at reset
//   CNT_W    width of the match counter
//
// Ports
//   clk         clock; all logic updates on posedge
//   rst         asynchronous reset, active low
//   in          serial data bit, sampled when en=1
//   en          bit-valid strobe; while low, the history holds
//   overlap     1 = overlapping detection, 0 = non-overlapping
//   pat_load    loads pattern_in and clears progress; has priority over en
//   pattern_in  new pattern; bit [SEQ_LEN-1] is the first bit expected
//   detected    registered match pulse
//   match_cnt   saturating match count
//   cnt_clr     synchronous clear of match_cnt
module moore_seq_detector_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] RST_PAT = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               en,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pattern_in,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
);

  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic               det_q, det_d;

  logic [SEQ_LEN-1:0] nh;
  logic [FILL_W-1:0]  nf;
  logic               match;

  // State register: the shift history, the fill count, the pattern and the
  // registered pulse. Reset discards all partial progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      det_q  <= det_d;
    end
  end

  // Next-state logic. The shift-register form lets a new pattern take effect
  // with no recomputation. The fill count keeps stale zeros in the history
  // from matching a pattern that starts with zeros. After a non-overlapping
  // hit, both the history and the fill count restart from empty.
  always_comb begin
    nh     = {hist_q[SEQ_LEN-2:0], in};
    nf     = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match  = (nf == FILL_FULL) && (nh == pat_q);
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    det_d  = 1'b0;
    if (pat_load) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      det_d = match;
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = nh;
        fill_d = nf;
      end
    end
  end

  // Output logic: the pulse comes straight from a register (Moore behaviour).
  always_comb begin
    detected = det_q;
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Match counter. It counts each pulse being registered and saturates at the
  // maximum value. A clear wins over an increment in the same cycle. A pattern
  // load leaves the count untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (det_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// tb_moore_seq_detector_param
//   Drives moore_seq_detector_param with directed and random serial traffic.
//   The expected detected/match_cnt after each clock comes from a reference
//   model. That model keeps the received bits in a queue and compares the last
//   SEQ_LEN of them against the pattern.
module tb_moore_seq_detector_param;

  localparam int SEQ_LEN = 4;
`ifdef SEQDET_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in = 1'b0;
  logic               en = 1'b0;
  logic               overlap = 1'b0;
  logic               pat_load = 1'b0;
  logic               cnt_clr = 1'b0;
  logic [SEQ_LEN-1:0] pattern_in = '0;
  logic               detected;
  logic [CNT_W-1:0]   match_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             det;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic               mbits[$];
  logic [SEQ_LEN-1:0] mpat;
  int                 mcnt;
  logic               done = 1'b0;

  always #5 clk = ~clk;

  moore_seq_detector_param #(
    .SEQ_LEN(SEQ_LEN),
    .RST_PAT(4'b1011),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .en(en),
    .overlap(overlap),
    .pat_load(pat_load),
    .pattern_in(pattern_in),
    .detected(detected),
    .match_cnt(match_cnt),
    .cnt_clr(cnt_clr)
  );

  // One comparison; prints a FAIL line on a mismatch.
  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compares the DUT outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    checkValue("detected", 32'(detected), 32'(e.det));
    checkValue("match_cnt", 32'(match_cnt), 32'(e.cnt));
  endtask

  function automatic void modelReset();
    mbits.delete();
    mpat = 4'b1011;
    mcnt = 0;
  endfunction

  // Reference model: matches the last SEQ_LEN bits since the last clear against the pattern.
  function automatic exp_t modelStep(input logic b, input logic e, input logic o,
                                     input logic pl, input logic [SEQ_LEN-1:0] p,
                                     input logic c);
    exp_t r;
    logic [SEQ_LEN-1:0] w;
    logic det;
    det = 1'b0;
    w = '0;
    if (pl) begin
      mpat = p;
      mbits.delete();
    end else if (e) begin
      mbits.push_back(b);
      if (mbits.size() > SEQ_LEN) void'(mbits.pop_front());
      if (mbits.size() == SEQ_LEN) begin
        for (int i = 0; i < SEQ_LEN; i++) w = {w[SEQ_LEN-2:0], mbits[i]};
        det = (w == mpat);
      end
      if (det && !o) mbits.delete();
    end
`ifdef SEQDET_COUNT_EN
    if (c) mcnt = 0;
    else if (det && mcnt < (1 << CNT_W) - 1) mcnt++;
`else
    mcnt = 0;
`endif
    r.det = det;
    r.cnt = CNT_W'(mcnt);
    return r;
  endfunction

  // Drives one cycle of inputs at the falling edge and queues its expected result.
  task automatic applyStimulus(input logic b, input logic e, input logic o, input logic pl,
                               input logic [SEQ_LEN-1:0] p, input logic c);
    @(negedge clk);
    rst        = 1'b1;
    in         = b;
    en         = e;
    overlap    = o;
    pat_load   = pl;
    pattern_in = p;
    cnt_clr    = c;
    exp_q.push_back(modelStep(b, e, o, pl, p, c));
  endtask

  // Asserts the asynchronous reset mid-cycle and checks that it clears the outputs at once.
  task automatic applyReset();
    exp_t z;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    modelReset();
    #1;
    checkValue("async_reset_detected", 32'(detected), 32'd0);
    checkValue("async_reset_cnt", 32'(match_cnt), 32'(mcnt));
    z.det = 1'b0;
    z.cnt = '0;
    exp_q.push_back(z);
  endtask

  // Sends bits v[n-1] down to v[0], with optional en=0 bubbles after each bit.
  task automatic sendBits(input logic [31:0] v, input int n, input logic o, input int bubbles);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(v[i], 1'b1, o, 1'b0, '0, 1'b0);
      for (int k = 0; k < bubbles; k++) applyStimulus(1'b0, 1'b0, o, 1'b0, '0, 1'b0);
    end
  endtask

  // Monitor: checks one scoreboard entry after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
      if (done) break;
    end
  end

  initial begin
    int wait_cycles;
    logic [SEQ_LEN-1:0] rp;
    modelReset();
    #1;
    checkValue("reset_detected", 32'(detected), 32'd0);
    checkValue("reset_cnt", 32'(match_cnt), 32'd0);
    applyReset();

    // T1 and T2: non-overlapping, then overlapping, on 1011011
    sendBits(32'b1011, 4, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    sendBits(32'b1011011, 7, 1'b0, 0);
    applyReset();
    sendBits(32'b1011011, 7, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);

    // T3: en bubbles between the bits
    applyReset();
    sendBits(32'b1011, 4, 1'b0, 2);

    // T4: load a new pattern mid-stream
    sendBits(32'b101, 3, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    sendBits(32'b0110, 4, 1'b0, 0);
    sendBits(32'b1011, 4, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b0);

    // T5: reset mid-sequence
    sendBits(32'b101, 3, 1'b0, 0);
    applyReset();
    sendBits(32'b1, 1, 1'b0, 0);
    sendBits(32'b1011, 4, 1'b0, 0);

    // T6: counter saturation and clear (a clear on a matching cycle wins)
    applyReset();
    for (int m = 0; m < 5; m++) sendBits(32'b1011, 4, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    sendBits(32'b101, 3, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    sendBits(32'b1011, 4, 1'b0, 0);

    // All-ones pattern with overlap: a pulse on every enabled 1
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    sendBits(32'b111111, 6, 1'b1, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset();
      end else if ($urandom_range(0, 49) == 0) begin
        rp = ($urandom_range(0, 3) == 0) ? '1 : SEQ_LEN'($urandom);
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, rp,
                      ($urandom_range(0, 39) == 0));
      end else begin
        applyStimulus(1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom), 1'b0,
                      SEQ_LEN'($urandom), ($urandom_range(0, 39) == 0));
      end
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkValue("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
